// File: rtl/func_operand_feeder.sv
// func_operand_feeder: operand scheduler in front of the func datapath.
// Buffers (a,b) pairs in a FIFO, issues one pair at a time to func, waits for
// the completion edge (or a watchdog timeout) and returns the tagged result on
// a valid/ready port.
// Ports:
//   clk_i, rst_i                    clock, async active-high reset
//   s_valid_i/s_ready_o/s_a_i/s_b_i operand input port
//   func_a_o/func_b_o               operands driven to func (held until next pop)
//   func_in_ready_o                 start strobe, ISSUE_CYCLES long
//   func_out_i/func_out_ready_i     func result and completion flag
//   m_valid_o/m_ready_i             result output handshake
//   m_a_o/m_b_o/m_result_o          operands and result (12'hFFF on timeout)
//   m_timeout_o                     result is a timeout marker
//   busy_o, level_o                 FSM not idle, FIFO occupancy
module func_operand_feeder #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned ISSUE_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       s_valid_i,
    output logic                       s_ready_o,
    input  logic [7:0]                 s_a_i,
    input  logic [7:0]                 s_b_i,
    output logic [7:0]                 func_a_o,
    output logic [7:0]                 func_b_o,
    output logic                       func_in_ready_o,
    input  logic [11:0]                func_out_i,
    input  logic                       func_out_ready_i,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic [7:0]                 m_a_o,
    output logic [7:0]                 m_b_o,
    output logic [11:0]                m_result_o,
    output logic                       m_timeout_o,
    output logic                       busy_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned LW  = PW + 1;
    localparam int unsigned ICW = (ISSUE_CYCLES > 1) ? $clog2(ISSUE_CYCLES) : 1;
    localparam int unsigned WW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t           state_q, state_d;
    logic [ICW-1:0]   issue_cnt_q, issue_cnt_d;
    logic [WW-1:0]    wdog_q, wdog_d;
    logic             edge_q, edge_d;

    logic [7:0]       mem_a_q [DEPTH];
    logic [7:0]       mem_b_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;

    logic             func_in_ready_q;
    logic [7:0]       func_a_q, func_b_q;
    logic             m_valid_q, m_timeout_q;
    logic [7:0]       m_a_q, m_b_q;
    logic [11:0]      m_result_q;

    logic             push_c, pop_c, cap_done_c, cap_to_c;

    assign s_ready_o = (level_q != LW'(DEPTH));
    assign push_c    = s_valid_i & s_ready_o;

    // Operand FIFO; level is registered so a push is never visible to pop in the same cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_a_q[i] <= '0;
                mem_b_q[i] <= '0;
            end
        end else begin
            if (push_c) begin
                mem_a_q[wr_ptr_q] <= s_a_i;
                mem_b_q[wr_ptr_q] <= s_b_i;
                wr_ptr_q          <= wr_ptr_q + PW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // FSM state, issue counter, watchdog and completion edge register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            wdog_q      <= '0;
            edge_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            wdog_q      <= wdog_d;
            edge_q      <= edge_d;
        end
    end

    // Next-state logic; only issue when the output register is free by capture time
    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        wdog_d      = wdog_q;
        edge_d      = edge_q;
        pop_c       = 1'b0;
        cap_done_c  = 1'b0;
        cap_to_c    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((level_q != '0) && (!m_valid_q || m_ready_i)) begin
                    pop_c       = 1'b1;
                    issue_cnt_d = '0;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue_cnt_q == ICW'(ISSUE_CYCLES - 1)) begin
                    // Prime the edge register so a level already high is not a completion
                    edge_d  = func_out_ready_i;
                    wdog_d  = '0;
                    state_d = S_WAIT;
                end else begin
                    issue_cnt_d = issue_cnt_q + ICW'(1);
                end
            end
            S_WAIT: begin
                edge_d = func_out_ready_i;
                if (func_out_ready_i && !edge_q) begin
                    cap_done_c = 1'b1;
                    state_d    = S_IDLE;
                end else if (wdog_q == WW'(TIMEOUT - 1)) begin
                    cap_to_c = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs toward func and the result port
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            func_in_ready_q <= 1'b0;
            func_a_q        <= '0;
            func_b_q        <= '0;
            m_valid_q       <= 1'b0;
            m_timeout_q     <= 1'b0;
            m_a_q           <= '0;
            m_b_q           <= '0;
            m_result_q      <= '0;
        end else begin
            func_in_ready_q <= (state_d == S_ISSUE);
            if (pop_c) begin
                func_a_q <= mem_a_q[rd_ptr_q];
                func_b_q <= mem_b_q[rd_ptr_q];
            end
            if (cap_done_c) begin
                m_result_q  <= func_out_i;
                m_a_q       <= func_a_q;
                m_b_q       <= func_b_q;
                m_valid_q   <= 1'b1;
                m_timeout_q <= 1'b0;
            end else if (cap_to_c) begin
                m_result_q  <= 12'hFFF;
                m_a_q       <= func_a_q;
                m_b_q       <= func_b_q;
                m_valid_q   <= 1'b1;
                m_timeout_q <= 1'b1;
            end else if (m_valid_q && m_ready_i) begin
                m_valid_q   <= 1'b0;
                m_timeout_q <= 1'b0;
            end
        end
    end

    assign func_in_ready_o = func_in_ready_q;
    assign func_a_o        = func_a_q;
    assign func_b_o        = func_b_q;
    assign m_valid_o       = m_valid_q;
    assign m_timeout_o     = m_timeout_q;
    assign m_a_o           = m_a_q;
    assign m_b_o           = m_b_q;
    assign m_result_o      = m_result_q;
    assign busy_o          = (state_q != S_IDLE);
    assign level_o         = level_q;

endmodule

// File: tb/tb_func_operand_feeder.sv
// Directed bench for func_operand_feeder: vector table plus corner sequences.
module tb_func_operand_feeder;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        s_valid_i = 1'b0;
    logic        s_ready_o;
    logic [7:0]  s_a_i = '0;
    logic [7:0]  s_b_i = '0;
    logic [7:0]  func_a_o, func_b_o;
    logic        func_in_ready_o;
    logic [11:0] func_out_i;
    logic        func_out_ready_i;
    logic        m_valid_o;
    logic        m_ready_i = 1'b1;
    logic [7:0]  m_a_o, m_b_o;
    logic [11:0] m_result_o;
    logic        m_timeout_o;
    logic        busy_o;
    logic [2:0]  level_o;

    func_operand_feeder dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_a_i(s_a_i), .s_b_i(s_b_i),
        .func_a_o(func_a_o), .func_b_o(func_b_o), .func_in_ready_o(func_in_ready_o),
        .func_out_i(func_out_i), .func_out_ready_i(func_out_ready_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_a_o(m_a_o), .m_b_o(m_b_o),
        .m_result_o(m_result_o), .m_timeout_o(m_timeout_o),
        .busy_o(busy_o), .level_o(level_o)
    );

    always #5 clk_i = ~clk_i;

    // func stand-in: result = 5*a + b, raised model_delay cycles after in_ready rises
    logic        model_en    = 1'b1;
    logic        model_resp  = 1'b1;
    int          model_delay = 3;
    logic        model_rdy   = 1'b0;
    logic [11:0] model_out   = '0;
    logic        man_rdy     = 1'b0;
    logic [11:0] man_out     = '0;
    logic        prev_ir     = 1'b0;
    logic        pend        = 1'b0;
    int          mcnt        = 0;
    logic [7:0]  ma = '0, mb = '0;

    assign func_out_ready_i = model_en ? model_rdy : man_rdy;
    assign func_out_i       = model_en ? model_out : man_out;

    function automatic logic [11:0] calc(input logic [7:0] a, input logic [7:0] b);
        return 12'(a) * 12'd5 + 12'(b);
    endfunction

    always @(negedge clk_i) begin
        if (func_in_ready_o && !prev_ir) begin
            pend      = model_resp;
            mcnt      = model_delay;
            ma        = func_a_o;
            mb        = func_b_o;
            model_rdy = 1'b0;
        end else if (pend) begin
            if (mcnt <= 1) begin
                model_rdy = 1'b1;
                model_out = calc(ma, mb);
                pend      = 1'b0;
            end else begin
                mcnt = mcnt - 1;
            end
        end
        prev_ir = func_in_ready_o;
    end

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [11:0] res;
        logic        to;
    } exp_t;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [11:0] res;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   rx_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard the handshake about to happen, then advance to negedge+1
    task automatic tick();
        exp_t e;
        if (!rst_i && m_valid_o && m_ready_i) begin
            checks++;
            rx_cnt++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard unexpected result actual=%h required=none", m_result_o);
            end else begin
                e = exp_q.pop_front();
                if (m_result_o !== e.res || m_a_o !== e.a || m_b_o !== e.b || m_timeout_o !== e.to) begin
                    errors++;
                    $display("FAIL scoreboard actual=a%h b%h r%h t%b required=a%h b%h r%h t%b",
                             m_a_o, m_b_o, m_result_o, m_timeout_o, e.a, e.b, e.res, e.to);
                end
            end
        end
        @(negedge clk_i);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b,
                        input logic [11:0] res, input logic to);
        exp_t e;
        int   n = 0;
        s_valid_i = 1'b1;
        s_a_i     = a;
        s_b_i     = b;
        while (!s_ready_o && n < 2000) begin
            tick();
            n++;
        end
        if (!s_ready_o) begin
            chk("push_timeout", 32'(s_ready_o), 32'd1);
        end else begin
            e.a = a; e.b = b; e.res = res; e.to = to;
            exp_q.push_back(e);
            tick();
        end
        s_valid_i = 1'b0;
    endtask

    task automatic wait_rx(input int target, input int budget);
        int n = 0;
        while (rx_cnt < target && n < budget) begin
            tick();
            n++;
        end
        if (rx_cnt < target) chk("wait_rx_timeout", 32'(rx_cnt), 32'(target));
    endtask

    task automatic wait_ir(input logic level, input int budget);
        int n = 0;
        while (func_in_ready_o !== level && n < budget) begin
            tick();
            n++;
        end
        chk("wait_in_ready", 32'(func_in_ready_o), 32'(level));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vec_t vecs [7];
        logic        bad;
        logic [11:0] snap_r;
        logic [7:0]  snap_a, snap_b;
        int          n;

        vecs[0] = '{8'd5,   8'd2,   12'h01B};
        vecs[1] = '{8'd0,   8'd0,   12'h000};
        vecs[2] = '{8'd255, 8'd255, 12'h5FA};
        vecs[3] = '{8'd16,  8'd1,   12'h051};
        vecs[4] = '{8'd100, 8'd7,   12'h1FB};
        vecs[5] = '{8'd1,   8'd200, 12'h0CD};
        vecs[6] = '{8'd200, 8'd3,   12'h3EB};

        @(negedge clk_i); #1;
        // Reset state
        chk("rst_level",    32'(level_o), 32'd0);
        chk("rst_m_valid",  32'(m_valid_o), 32'd0);
        chk("rst_in_ready", 32'(func_in_ready_o), 32'd0);
        chk("rst_busy",     32'(busy_o), 32'd0);
        chk("rst_func_a",   32'(func_a_o), 32'd0);
        chk("rst_m_result", 32'(m_result_o), 32'd0);
        chk("rst_m_timeout",32'(m_timeout_o), 32'd0);
        tick();
        rst_i = 1'b0;
        tick();

        // Test 1: single call, exact issue pulse and latency
        model_delay = 100;
        push(8'd5, 8'd2, 12'h01B, 1'b0);
        chk("t1_ir_cycle1", 32'(func_in_ready_o), 32'd0);
        chk("t1_busy_cycle1", 32'(busy_o), 32'd0);
        tick();
        chk("t1_ir_cycle2", 32'(func_in_ready_o), 32'd1);
        chk("t1_func_a", 32'(func_a_o), 32'd5);
        chk("t1_func_b", 32'(func_b_o), 32'd2);
        tick();
        chk("t1_ir_cycle3", 32'(func_in_ready_o), 32'd1);
        tick();
        chk("t1_ir_cycle4", 32'(func_in_ready_o), 32'd0);
        chk("t1_busy_wait", 32'(busy_o), 32'd1);
        wait_rx(1, 300);

        // Vector table
        model_delay = 3;
        for (int i = 0; i < 7; i++) begin
            push(vecs[i].a, vecs[i].b, vecs[i].res, 1'b0);
            wait_rx(rx_cnt + 1, 200);
        end

        // Test 2: fill the FIFO behind a busy WAIT
        model_delay = 20;
        n = rx_cnt;
        push(8'd10, 8'd1, calc(8'd10, 8'd1), 1'b0);
        wait_ir(1'b1, 20);
        wait_ir(1'b0, 20);
        for (int i = 0; i < 4; i++) push(8'(20 + i), 8'(i), calc(8'(20 + i), 8'(i)), 1'b0);
        chk("t2_level_full", 32'(level_o), 32'd4);
        chk("t2_s_ready_full", 32'(s_ready_o), 32'd0);
        push(8'd30, 8'd9, calc(8'd30, 8'd9), 1'b0);
        wait_rx(n + 6, 1000);

        // Test 3: downstream stall blocks further issue
        model_delay = 3;
        m_ready_i = 1'b0;
        n = rx_cnt;
        push(8'd40, 8'd4, calc(8'd40, 8'd4), 1'b0);
        bad = 1'b1;
        for (int i = 0; i < 50 && bad; i++) begin
            if (m_valid_o) bad = 1'b0;
            else tick();
        end
        chk("t3_m_valid", 32'(m_valid_o), 32'd1);
        push(8'd41, 8'd5, calc(8'd41, 8'd5), 1'b0);
        push(8'd42, 8'd6, calc(8'd42, 8'd6), 1'b0);
        snap_r = m_result_o; snap_a = m_a_o; snap_b = m_b_o;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!m_valid_o || func_in_ready_o || m_result_o !== snap_r ||
                m_a_o !== snap_a || m_b_o !== snap_b) bad = 1'b1;
            tick();
        end
        chk("t3_stall_hold", 32'(bad), 32'd0);
        chk("t3_stall_result", 32'(m_result_o), 32'(calc(8'd40, 8'd4)));
        chk("t3_level_queued", 32'(level_o), 32'd2);
        m_ready_i = 1'b1;
        wait_rx(n + 3, 200);

        // Test 4: watchdog timeout, then the next pair issues
        model_resp = 1'b0;
        n = rx_cnt;
        push(8'd50, 8'd5, 12'hFFF, 1'b1);
        wait_ir(1'b1, 20);
        model_resp = 1'b1;
        push(8'd51, 8'd6, calc(8'd51, 8'd6), 1'b0);
        wait_ir(1'b0, 20);
        begin
            int w = 0;
            while (!m_valid_o && w < 400) begin
                w++;
                tick();
            end
            chk("t4_wait_cycles", 32'(w), 32'd255);
        end
        chk("t4_timeout_flag", 32'(m_timeout_o), 32'd1);
        chk("t4_timeout_result", 32'(m_result_o), 32'hFFF);
        wait_rx(n + 2, 200);

        // Test 5: reset during WAIT discards everything; late completion ignored
        model_delay = 30;
        push(8'd60, 8'd1, calc(8'd60, 8'd1), 1'b0);
        push(8'd61, 8'd2, calc(8'd61, 8'd2), 1'b0);
        wait_ir(1'b1, 20);
        wait_ir(1'b0, 20);
        tick(); tick();
        rst_i = 1'b1;
        #1;
        chk("t5_rst_level", 32'(level_o), 32'd0);
        chk("t5_rst_busy", 32'(busy_o), 32'd0);
        chk("t5_rst_m_valid", 32'(m_valid_o), 32'd0);
        chk("t5_rst_func_a", 32'(func_a_o), 32'd0);
        exp_q.delete();
        tick();
        rst_i = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (m_valid_o || busy_o || func_in_ready_o) bad = 1'b1;
            tick();
        end
        chk("t5_late_completion_ignored", 32'(bad), 32'd0);
        chk("t5_late_rdy_seen", 32'(func_out_ready_i), 32'd1);

        // Test 6: stale high across issue; only the second rise completes
        model_en = 1'b0;
        man_rdy  = 1'b1;
        man_out  = 12'h123;
        push(8'd9, 8'd9, 12'hABC, 1'b0);
        wait_ir(1'b1, 20);
        wait_ir(1'b0, 20);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (m_valid_o || !busy_o) bad = 1'b1;
            tick();
        end
        chk("t6_stale_high_ignored", 32'(bad), 32'd0);
        man_rdy = 1'b0;
        tick(); tick(); tick();
        chk("t6_fall_no_capture", 32'(m_valid_o), 32'd0);
        man_out = 12'hABC;
        man_rdy = 1'b1;
        tick();
        chk("t6_capture_latency", 32'(m_valid_o), 32'd1);
        chk("t6_capture_value", 32'(m_result_o), 32'hABC);
        n = rx_cnt;
        wait_rx(n + 1, 10);
        man_rdy = 1'b0;
        tick();
        chk("t6_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
